bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
Round-robin arbiter that shares one vaild/ready sink (e.g. a destination_v3 instance) between NUM_REQ vaild/ready sources (e.g. source_v3 instances).
- A grant is held for a burst of up to MAX_BURST beats.
- Winning data passes through a one-entry registered output stage, so the sink sees registered vaild/data.
- Sits between the source bank and the destination, so one sink is shared with fair access.

Parameters:
WIDTH, 9, data width per beat
NUM_REQ, 4, number of requesters (>=1)
MAX_BURST, 4, maximum consecutive beats per grant (>=1)
IDX_W, $clog2(NUM_REQ) (min 1), requester index width (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on rising edge
s_rst  input  1  asynchronous, active-low reset (0 = reset)
s_vaild  input  NUM_REQ  per-requester valid
s_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
s_ready  output  NUM_REQ  per-requester ready, one-hot or zero
m_vaild  output  1  output beat valid (registered)
m_data  output  WIDTH  output beat data (registered)
m_src  output  IDX_W  index of requester that produced m_data (registered)
m_ready  input  1  sink ready
busy  output  1  1 while FSM in GRANT

Behaviour:
- Reset (s_rst=0, asynchronous):
  - Outputs: m_vaild=0, m_data=0, m_src=0, busy=0.
  - Internal: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - Any beat held in the output register is discarded.
  - s_ready=0 while in reset.
- Handshake rules:
  - A beat transfers on a rising edge where vaild&&ready are both 1.
  - Sources hold vaild and data stable until accepted; the arbiter obeys the same rule on m_*.
- Output stage:
  - load = s_vaild[grant] && s_ready[grant].
  - On load: m_vaild<=1, m_data<=s_data[grant], m_src<=grant.
  - Else if m_ready: m_vaild<=0, m_data and m_src hold.
  - Else everything holds.
  - Latency: accepted beat appears on m_* the next cycle.
  - Throughput: 1 beat/cycle while m_ready=1.
- s_ready[i] = (state==GRANT) && (grant==i) && (!m_vaild || m_ready). Combinational from m_ready; no other combinational path from inputs to outputs.
- FSM IDLE:
  - s_ready=0.
  - If any s_vaild bit is set, grant <= first requester searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; beat_cnt<=0; go to GRANT.
  - Otherwise stay in IDLE.
- FSM GRANT: each load increments beat_cnt. Go to IDLE next cycle when either:
  - a load occurs with beat_cnt==MAX_BURST-1 (burst complete), or
  - s_vaild[grant]==0 in that cycle (requester idle between beats).
  - On exit: rr_ptr <= (grant+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
- Grant switch costs exactly one IDLE cycle. The output register may still drain during it, since m_* is independent of state.
- No mid-beat switch: grant only changes in IDLE, so a beat is never half-accepted.
- NUM_REQ=1: the single requester always wins; rr_ptr stays 0.
- MAX_BURST=1: one beat per grant, then re-arbitrate.
- m_ready low while m_vaild=1: s_ready all 0; m_* held stable; beat_cnt unchanged; grant kept.
- Simultaneous load and m_ready=1: the new beat replaces the old one, with no bubble.
- beat_cnt width: $clog2(MAX_BURST+1).

Test Plan:
1. Only req 1 active, 10 beats (data 0x001..0x00A), m_ready=1 → m_data 0x001..0x00A with m_src=1 in order. Bursts of 4, 4, 2 separated by one idle cycle each. First beat appears 2 cycles after vaild rises (IDLE→GRANT, then register).
2. All 4 requesters continuously valid, MAX_BURST=4, req i data = i*0x40+k → m_src sequence 0×4, 1×4, 2×4, 3×4, 0×4; no beat lost or duplicated; each source sees exactly 4 accepts per round.
3. Stream from req 2 with m_ready toggled randomly 50% → m_vaild/m_data/m_src stable while m_ready=0; s_ready[2]=0 whenever m_vaild=1 && m_ready=0; output sequence equals input sequence.
4. Req 3 sends 2 beats then drops vaild; req 0 valid → grant released after 2 beats; rr_ptr wraps to 0; req 0 granted next.
5. Reset asserted mid-burst (after 2 of 4 beats, m_vaild=1) → m_vaild, busy, s_ready go 0 immediately (asynchronously). After release, arbitration restarts from req 0 with beat_cnt=0.
6. NUM_REQ=1, MAX_BURST=1 build, continuous valid → one beat every 2 cycles, m_src always 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin burst arbiter sharing one valid/ready sink among NUM_REQ sources
module bus_rr_arbiter #(
  parameter int WIDTH = 9,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 4,
  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     s_rst,
  input  logic [NUM_REQ-1:0]       s_vaild,
  input  logic [NUM_REQ*WIDTH-1:0] s_data,
  output logic [NUM_REQ-1:0]       s_ready,
  output logic                     m_vaild,
  output logic [WIDTH-1:0]         m_data,
  output logic [IDX_W-1:0]         m_src,
  input  logic                     m_ready,
  output logic                     busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt, rr_ptr, rr_nxt, pick;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic [WIDTH-1:0] sel_data;
  logic sel_vaild, open, load, last;
  int best;
  assign busy = state == GRANT;
  assign open = busy && (!m_vaild || m_ready);
  assign load = open && sel_vaild;
  assign last = load && beat_cnt == CNT_W'(MAX_BURST - 1);
  // rotating-priority search from rr_ptr, granted requester mux and one-hot ready
  always_comb begin
    pick = rr_ptr;
    best = NUM_REQ;
    sel_vaild = 1'b0;
    sel_data = '0;
    s_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_vaild[i] && (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ < best) begin
        best = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
        pick = IDX_W'(i);
      end
      if (grant == IDX_W'(i)) begin
        sel_vaild = s_vaild[i];
        sel_data = s_data[i*WIDTH +: WIDTH];
      end
      s_ready[i] = open && grant == IDX_W'(i);
    end
  end
  // grant a new requester from IDLE; leave GRANT when the burst completes or the requester goes idle
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt = rr_ptr;
    cnt_nxt = beat_cnt;
    if (state == IDLE) begin
      if (|s_vaild) begin
        state_nxt = GRANT;
        grant_nxt = pick;
        cnt_nxt = '0;
      end
    end else begin
      cnt_nxt = load ? beat_cnt + CNT_W'(1) : beat_cnt;
      if (last || !sel_vaild) begin
        state_nxt = IDLE;
        rr_nxt = grant == IDX_W'(NUM_REQ - 1) ? '0 : grant + IDX_W'(1);
      end
    end
  end
  // arbitration state registers
  always_ff @(posedge clk or negedge s_rst)
    if (!s_rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      rr_ptr <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  // one-entry output register: load replaces, sink acceptance empties
  always_ff @(posedge clk or negedge s_rst)
    if (!s_rst) begin
      m_vaild <= 1'b0;
      m_data <= '0;
      m_src <= '0;
    end else if (load) begin
      m_vaild <= 1'b1;
      m_data <= sel_data;
      m_src <= grant;
    end else if (m_ready) m_vaild <= 1'b0;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed checks of arbitration order, bursts, backpressure, reset and single-requester build
module tb_bus_rr_arbiter;
  logic clk = 0, s_rst = 0, m_ready = 0;
  logic [3:0] s_vaild, s_ready;
  logic [35:0] s_data;
  logic m_vaild, busy;
  logic [8:0] m_data;
  logic [1:0] m_src;
  logic v1, r1, mv1, mr1 = 0, b1;
  logic [8:0] d1, md1;
  logic [0:0] ms1;
  int checks = 0, errors = 0;
  int cnt[4], lim[4], base[4];
  int c1 = 0;
  bit en1 = 0;
  logic [10:0] oq[$];
  logic [10:0] hv;
  logic hold;

  bus_rr_arbiter #(.WIDTH(9), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk(clk), .s_rst(s_rst), .s_vaild(s_vaild), .s_data(s_data), .s_ready(s_ready),
    .m_vaild(m_vaild), .m_data(m_data), .m_src(m_src), .m_ready(m_ready), .busy(busy));

  bus_rr_arbiter #(.WIDTH(9), .NUM_REQ(1), .MAX_BURST(1)) u1 (
    .clk(clk), .s_rst(s_rst), .s_vaild(v1), .s_data(d1), .s_ready(r1),
    .m_vaild(mv1), .m_data(md1), .m_src(ms1), .m_ready(mr1), .busy(b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      s_vaild[i] = cnt[i] < lim[i];
      s_data[i*9 +: 9] = 9'(base[i] + cnt[i]);
    end
    v1 = en1;
    d1 = 9'(c1);
  endtask

  task automatic setsrc(input int i, input int b, input int l);
    base[i] = b;
    lim[i] = l;
    cnt[i] = 0;
  endtask

  task automatic tick();
    logic [3:0] acc;
    logic acc1;
    #1;
    acc = s_vaild & s_ready;
    acc1 = v1 & r1;
    if (m_vaild && m_ready) oq.push_back({m_src, m_data});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
    if (acc1) c1++;
    drive();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) setsrc(i, 0, 0);
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_m_vaild", m_vaild, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    s_rst = 1;
    tick();
    // single requester, 10 beats in bursts of 4,4,2
    m_ready = 1;
    setsrc(1, 1, 10);
    drive();
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("t1_vaild_e%0d", e), m_vaild, (e >= 2 && e <= 5) || (e >= 7 && e <= 10) || e == 12 || e == 13);
      chk($sformatf("t1_busy_e%0d", e), busy, (e >= 1 && e <= 4) || (e >= 6 && e <= 9) || (e >= 11 && e <= 13));
      if ((e >= 2 && e <= 5) || (e >= 7 && e <= 10) || e == 12 || e == 13) begin
        chk($sformatf("t1_data_e%0d", e), m_data, e <= 5 ? e - 1 : e <= 10 ? e - 2 : e - 3);
        chk($sformatf("t1_src_e%0d", e), m_src, 1);
      end
    end
    // req 3 releases after 2 beats, pointer wraps, req 0 follows
    setsrc(3, 'h30, 2);
    setsrc(0, 'h100, 2);
    drive();
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("t4_vaild_e%0d", e), m_vaild, e == 2 || e == 3 || e == 6 || e == 7);
      if (e == 2 || e == 3) begin
        chk($sformatf("t4_src_e%0d", e), m_src, 3);
        chk($sformatf("t4_data_e%0d", e), m_data, 'h30 + e - 2);
      end
      if (e == 6 || e == 7) begin
        chk($sformatf("t4_src_e%0d", e), m_src, 0);
        chk($sformatf("t4_data_e%0d", e), m_data, 'h100 + e - 6);
      end
    end
    // asynchronous reset in the middle of a burst
    setsrc(1, 'h50, 4);
    drive();
    tick();
    tick();
    tick();
    chk("t5_pre_vaild", m_vaild, 1);
    chk("t5_pre_data", m_data, 'h51);
    chk("t5_pre_busy", busy, 1);
    #2;
    s_rst = 0;
    #1;
    chk("t5_async_vaild", m_vaild, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", s_ready, 0);
    chk("t5_async_data", m_data, 0);
    lim[1] = 0;
    drive();
    tick();
    tick();
    s_rst = 1;
    // all four requesters: restart from req 0, bursts of 4
    setsrc(0, 'h000, 8);
    setsrc(1, 'h040, 4);
    setsrc(2, 'h080, 4);
    setsrc(3, 'h0c0, 4);
    drive();
    oq.delete();
    for (int n = 0; n < 150 && oq.size() < 20; n++) tick();
    chk("t2_count", oq.size(), 20);
    for (int k = 0; k < 20 && k < oq.size(); k++)
      chk($sformatf("t2_beat%0d", k), oq[k], {2'((k / 4) % 4), 9'(((k / 4) % 4) * 'h40 + (k < 16 ? k % 4 : 4 + k % 4))});
    for (int i = 0; i < 4; i++) chk($sformatf("t2_accepts%0d", i), cnt[i], i == 0 ? 8 : 4);
    // backpressure on a stream from req 2
    setsrc(2, 'h80, 12);
    drive();
    oq.delete();
    for (int n = 0; n < 300 && oq.size() < 12; n++) begin
      m_ready = 1'($urandom_range(0, 1));
      #1;
      hold = m_vaild && !m_ready;
      hv = {m_src, m_data};
      if (hold) chk("t3_sready_blocked", s_ready[2], 0);
      tick();
      if (hold) chk("t3_hold", {m_vaild, m_src, m_data}, {1'b1, hv});
    end
    m_ready = 1;
    chk("t3_count", oq.size(), 12);
    for (int k = 0; k < 12 && k < oq.size(); k++)
      chk($sformatf("t3_beat%0d", k), oq[k], {2'd2, 9'('h80 + k)});
    // single requester, single-beat bursts: one beat every two cycles
    mr1 = 1;
    en1 = 1;
    c1 = 0;
    drive();
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("t6_vaild_e%0d", e), mv1, e % 2 == 0);
      if (e % 2 == 0) begin
        chk($sformatf("t6_data_e%0d", e), md1, e / 2 - 1);
        chk($sformatf("t6_src_e%0d", e), ms1, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
